mem_access_unit: RTL

Load/store access controller between the execute stage and `data_memory`. It converts byte-addressed RISC-V loads and stores (lb/lh/lw/lbu/lhu/sb/sh/sw) into word-wide accesses on the single-port, one-cycle-read-latency data RAM. Sub-word stores are performed as read-modify-write. Misaligned requests are detected and rejected before any memory access.

---
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
// ----------------------------------------------------------------------------
// Load/store access controller sitting between the execute stage and the
// single-port data RAM (one-cycle read latency). Byte-addressed RISC-V
// loads and stores (lb/lh/lw/lbu/lhu/sb/sh/sw) become word-wide RAM
// accesses:
//   * word store        : IDLE -> WRITE -> IDLE
//   * byte/half store   : IDLE -> READ -> MERGE -> IDLE (read-modify-write)
//   * load              : IDLE -> READ -> LOAD -> IDLE
//   * misaligned/illegal: IDLE -> ERR -> IDLE (no RAM access at all)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend sub-word loads
//   req_addr          byte address
//   req_wdata         store data (low bits used for sub-word stores)
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         formatted load data (0 for stores and errors)
//   rsp_misaligned    qualifies rsp_valid: request was rejected
//   mem_addr          RAM word address {2'b00, addr[31:2]}
//   write_data        RAM write enable
//   mem_write         RAM write data
//   mem_read          RAM read data, valid the cycle after address sampling
//
// ADDR_W is the word-address width of the attached RAM. The RAM ignores
// mem_addr bits at and above ADDR_W, which is what makes addresses wrap.
// ============================================================================
module mem_access_unit #(
   parameter int ADDR_W = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_misaligned,
   output logic [31:0] mem_addr,
   output logic        write_data,
   output logic [31:0] mem_write,
   input  logic [31:0] mem_read
);

   // FSM encoding
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] READ  = 3'd1;
   localparam logic [2:0] LOAD  = 3'd2;
   localparam logic [2:0] MERGE = 3'd3;
   localparam logic [2:0] WRITE = 3'd4;
   localparam logic [2:0] ERR   = 3'd5;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [2:0]  state;
   logic [2:0]  state_nxt;

   // Request fields captured at acceptance; everything downstream works
   // only from these copies, so req_* may change freely while busy.
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic        accept;
   logic        misaligned;
   logic [31:0] merged;
   logic [31:0] load_data;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign accept = req_valid && (state == IDLE);

   // Alignment check on the incoming request. Bytes can never be
   // misaligned; size 11 is always rejected.
   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = req_addr[0];
         SZ_WORD: misaligned = |req_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Every non-IDLE state lasts one cycle; the final
   // state of each sequence always returns to IDLE, which gives the one
   // idle-ready cycle between back-to-back requests.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (misaligned) begin
                  state_nxt = ERR;
               end else if (req_we && (req_size == SZ_WORD)) begin
                  state_nxt = WRITE;
               end else begin
                  state_nxt = READ;
               end
            end
         end
         READ:    state_nxt = we_q ? MERGE : LOAD;
         LOAD:    state_nxt = IDLE;
         MERGE:   state_nxt = IDLE;
         WRITE:   state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture. Reset clears the address so mem_addr starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
      end else if (accept) begin
         we_q    <= req_we;
         size_q  <= req_size;
         uns_q   <= req_unsigned;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Read-modify-write merge: the word just read has the addressed
   // byte or half replaced by the low bits of the store data.
   always_comb begin
      merged = mem_read;
      case (size_q)
         SZ_BYTE: begin
            case (addr_q[1:0])
               2'd0:    merged[7:0]   = wdata_q[7:0];
               2'd1:    merged[15:8]  = wdata_q[7:0];
               2'd2:    merged[23:16] = wdata_q[7:0];
               default: merged[31:24] = wdata_q[7:0];
            endcase
         end
         SZ_HALF: begin
            if (addr_q[1]) begin
               merged[31:16] = wdata_q[15:0];
            end else begin
               merged[15:0] = wdata_q[15:0];
            end
         end
         default: merged = wdata_q;
      endcase
   end

   // Lane selection for loads
   always_comb begin
      byte_lane = mem_read[7:0];
      case (addr_q[1:0])
         2'd0:    byte_lane = mem_read[7:0];
         2'd1:    byte_lane = mem_read[15:8];
         2'd2:    byte_lane = mem_read[23:16];
         default: byte_lane = mem_read[31:24];
      endcase
      half_lane = addr_q[1] ? mem_read[31:16] : mem_read[15:0];
   end

   // Load formatting: sign- or zero-extend sub-word lanes, words pass.
   always_comb begin
      load_data = mem_read;
      case (size_q)
         SZ_BYTE: load_data = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
         SZ_HALF: load_data = {{16{half_lane[15] & ~uns_q}}, half_lane};
         default: load_data = mem_read;
      endcase
   end

   // Outputs are pure decodes of the state register and registered
   // request, so an asynchronous reset clears them immediately and no
   // req_* input reaches an output combinationally.
   assign req_ready      = (state == IDLE);
   assign write_data     = (state == WRITE) || (state == MERGE);
   assign rsp_valid      = (state == LOAD) || (state == WRITE) ||
                           (state == MERGE) || (state == ERR);
   assign rsp_misaligned = (state == ERR);
   assign mem_addr       = {2'b00, addr_q[31:2]};

   always_comb begin
      mem_write = 32'h0;
      case (state)
         WRITE:   mem_write = wdata_q;
         MERGE:   mem_write = merged;
         default: mem_write = 32'h0;
      endcase
   end

   assign rsp_rdata = (state == LOAD) ? load_data : 32'h0;

endmodule
